// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size encodings and latency limits for the data memory LSU.
// Holds no ports; imported by data_mem_lsu and dmem_align.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // Bytes touched by an access of size s. Reserved returns 1 so that
    // callers can use it in range arithmetic; the size itself is flagged
    // as an error separately.
    function automatic int unsigned size_bytes(
        input size_e       s,
        input int unsigned word_bytes
    );
        int unsigned n;
        n = 1;
        unique case (s)
            SZ_BYTE: n = 1;
            SZ_HALF: n = 2;
            SZ_WORD: n = word_bytes;
            default: n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: selects the addressed byte lanes of a memory word, right-aligns them
// and zero/sign-extends. Ports: word, lane, size, sgn in; rdata out.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 2
) (
    input  logic [DATA_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    input  size_e             size,
    input  logic              sgn,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] sh;

    assign sh = word >> {lane, 3'b000};

    // Word accesses are always lane 0 when legal, so sh equals word there.
    always_comb begin
        rdata = '0;
        unique case (size)
            SZ_BYTE: begin
                if (sgn) rdata = DATA_W'($signed(sh[7:0]));
                else     rdata = DATA_W'(sh[7:0]);
            end
            SZ_HALF: begin
                if (sgn) rdata = DATA_W'($signed(sh[15:0]));
                else     rdata = DATA_W'(sh[15:0]);
            end
            SZ_WORD: rdata = sh;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable data memory behind a valid/ready load/store port.
// Ports: clk, rst_n; req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata;
// resp_valid/resp_ready/resp_rdata/resp_err. Responses return LATENCY cycles after accept.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT    = (LATENCY < LAT_MIN) ? LAT_MIN :
                            (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

    size_e             size;
    logic [31:0]       word_idx;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       need;
    logic              misalign;
    logic              oor;
    logic              err;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] wshift;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] ld_data;
    logic              advance;
    logic              accept;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LAT-1:0]    pv;
    logic [LAT-1:0]    pe;
    logic [DATA_W-1:0] pd [LAT];

    // Address decode
    assign size     = size_e'(req_size);
    assign word_idx = req_addr / 32'(BYTES);
    assign lane     = LANE_W'(req_addr % 32'(BYTES));
    assign idx      = IDX_W'(word_idx);
    assign need     = 32'(size_bytes(size, BYTES));

    always_comb begin
        misalign = 1'b0;
        unique case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = req_addr[0];
            SZ_WORD: misalign = (lane != '0);
            default: misalign = 1'b1;
        endcase
        // An access that would spill past the end of the word is illegal
        // even when its start is aligned.
        if (32'(lane) + need > 32'(BYTES)) misalign = 1'b1;
    end

    assign oor = (word_idx >= 32'(DEPTH));
    assign err = misalign || oor;

    always_comb begin
        be = '0;
        unique case (size)
            SZ_BYTE: be = BYTES'(1) << lane;
            SZ_HALF: be = BYTES'(3) << lane;
            SZ_WORD: be = '1;
            default: be = '0;
        endcase
    end

    // Handshake: the whole pipe moves together, so a request can only
    // enter when the output slot is free or being drained this cycle.
    assign advance   = !pv[LAT-1] || resp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    // Store path
    assign wshift = req_wdata << {lane, 3'b000};

    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wshift[b*8 +: 8];
            end
        end
    end

    // Load path: the read is taken before this edge's write, and only one
    // request is accepted per edge, so an earlier store is always visible.
    assign rword = mem[idx];

    dmem_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_align (
        .word  (rword),
        .lane  (lane),
        .size  (size),
        .sgn   (req_signed),
        .rdata (aligned)
    );

    assign ld_data = (req_we || err) ? '0 : aligned;

    // Response pipeline; empty slots carry zero data so idle outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < LAT; i++) pd[i] <= '0;
        end else if (advance) begin
            pv[0] <= req_valid;
            pe[0] <= req_valid && err;
            pd[0] <= req_valid ? ld_data : '0;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign resp_valid = pv[LAT-1];
    assign resp_err   = pe[LAT-1];
    assign resp_rdata = pd[LAT-1];

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: randomized and directed bench for data_mem_lsu
// against a byte-array reference model (LATENCY 3, DEPTH 256, 32-bit).
module tb_data_mem_lsu;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    always #5 clk = ~clk;

    data_mem_lsu #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } dir_t;

    exp_t       expq[$];
    logic [7:0] mref [DEPTH*4];
    int         total = 0;
    int         passed = 0;
    int         cyc_n = 0;

    // Reference model: memory is a flat byte array indexed by byte address.
    function automatic void model(
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        er
    );
        int          nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || (a % nb != 0) || (a / 4 >= DEPTH);
        rd = '0;
        v  = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mref[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) v = v | (32'(mref[a + i]) << (8 * i));
            if (nb < 4 && sg && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
        end
    endfunction

    // One clock of stimulus; samples outputs 1 time unit after the falling edge.
    task automatic drive(
        input  logic        v,
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic        rr,
        output logic        acc,
        output logic        rdy,
        output logic        rv,
        output logic        got,
        output logic [31:0] rd,
        output logic        er,
        output exp_t        ex,
        output int          lat
    );
        exp_t        n;
        logic [31:0] mrd;
        logic        mer;
        @(negedge clk);
        req_valid  = v;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = rr;
        #1;
        rdy = req_ready;
        rv  = resp_valid;
        got = rv && rr;
        rd  = resp_rdata;
        er  = resp_err;
        acc = v && rdy;
        ex.rd  = 'x;
        ex.er  = 1'bx;
        ex.cyc = cyc_n;
        lat    = -1;
        if (got && expq.size() > 0) begin
            ex  = expq.pop_front();
            lat = cyc_n - ex.cyc;
        end
        if (acc) begin
            model(we, sz, sg, a, wd, mrd, mer);
            n.rd  = mrd;
            n.er  = mer;
            n.cyc = cyc_n;
            expq.push_back(n);
        end
        cyc_n++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", resp_valid);
        else passed++;
        total++;
        if (resp_rdata !== '0) $display("FAIL rst_rdata got %h want 0", resp_rdata);
        else passed++;
        total++;
        if (resp_err !== 1'b0) $display("FAIL rst_err got %b want 0", resp_err);
        else passed++;
        total++;
        if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL post_rst got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        else passed++;
    endtask

    task automatic test_fill;
        logic acc, rdy, rv, got, er;
        logic [31:0] rd;
        exp_t ex;
        int lat, stalls;
        stalls = 0;
        for (int i = 0; i < DEPTH + 40; i++) begin
            if (i < DEPTH)
                drive(1'b1, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b1,
                      acc, rdy, rv, got, rd, er, ex, lat);
            else
                drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1,
                      acc, rdy, rv, got, rd, er, ex, lat);
            if (i < DEPTH && !acc) stalls++;
            if (got) begin
                total++;
                if (rd !== ex.rd || er !== ex.er)
                    $display("FAIL fill_resp got %h/%b want %h/%b", rd, er, ex.rd, ex.er);
                else passed++;
            end
        end
        total++;
        if (stalls != 0) $display("FAIL fill_throughput stalls got %0d want 0", stalls);
        else passed++;
        total++;
        if (expq.size() != 0) $display("FAIL fill_drain left got %0d want 0", expq.size());
        else passed++;
    endtask

    task automatic test_directed;
        dir_t t[16];
        logic acc, rdy, rv, got, er;
        logic [31:0] rd;
        exp_t ex;
        int lat, sent, seen;
        t[0]  = '{1'b1, 2'd2, 1'b0, 32'h000, 32'h11223344, 32'h00000000, 1'b0};
        t[1]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        t[2]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        t[3]  = '{1'b1, 2'd0, 1'b0, 32'h013, 32'h00000080, 32'h00000000, 1'b0};
        t[4]  = '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        t[5]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        t[6]  = '{1'b0, 2'd1, 1'b1, 32'h011, 32'h0,        32'h00000000, 1'b1};
        t[7]  = '{1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 32'h00000000, 1'b1};
        t[8]  = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'h11223344, 1'b0};
        t[9]  = '{1'b1, 2'd2, 1'b0, 32'h020, 32'h12345678, 32'h00000000, 1'b0};
        t[10] = '{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h12345678, 1'b0};
        t[11] = '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'h000080AD, 1'b0};
        t[12] = '{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'hFFFF80AD, 1'b0};
        t[13] = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'h00000080, 1'b0};
        t[14] = '{1'b0, 2'd3, 1'b0, 32'h010, 32'h0,        32'h00000000, 1'b1};
        t[15] = '{1'b0, 2'd2, 1'b0, 32'h012, 32'h0,        32'h00000000, 1'b1};
        sent = 0;
        seen = 0;
        for (int k = 0; k < 100 && seen < 16; k++) begin
            if (sent < 16)
                drive(1'b1, t[sent].we, t[sent].sz, t[sent].sg, t[sent].a, t[sent].wd,
                      1'b1, acc, rdy, rv, got, rd, er, ex, lat);
            else
                drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1,
                      acc, rdy, rv, got, rd, er, ex, lat);
            if (acc) sent++;
            if (got) begin
                total++;
                if (rd !== t[seen].rd || er !== t[seen].er)
                    $display("FAIL dir[%0d] got %h/%b want %h/%b",
                             seen, rd, er, t[seen].rd, t[seen].er);
                else passed++;
                total++;
                if (lat != LAT) $display("FAIL dir_lat[%0d] got %0d want %0d", seen, lat, LAT);
                else passed++;
                seen++;
            end
        end
        total++;
        if (seen != 16) $display("FAIL dir_count got %0d want 16", seen);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic acc, rdy, rv, got, er, rr, p_stall, p_er;
        logic [31:0] rd, p_rd;
        exp_t ex;
        int lat, sent, blocked;
        sent = 0;
        blocked = 0;
        p_stall = 1'b0;
        p_rd = '0;
        p_er = 1'b0;
        for (int k = 0; k < 60; k++) begin
            rr = !(k >= 4 && k < 9);
            drive(sent < 12, 1'b0, 2'd2, 1'b0, 32'($urandom_range(0, DEPTH - 1) * 4), '0,
                  rr, acc, rdy, rv, got, rd, er, ex, lat);
            if (acc) sent++;
            if (sent < 12 && !rdy) blocked++;
            if (rv && !rr) begin
                total++;
                if (rdy !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", k, rdy);
                else passed++;
            end
            if (p_stall) begin
                total++;
                if (rv !== 1'b1 || rd !== p_rd || er !== p_er)
                    $display("FAIL bp_hold[%0d] got %b/%h/%b want 1/%h/%b",
                             k, rv, rd, er, p_rd, p_er);
                else passed++;
            end
            p_stall = rv && !rr;
            p_rd = rd;
            p_er = er;
            if (got) begin
                total++;
                if (rd !== ex.rd || er !== ex.er)
                    $display("FAIL bp_resp got %h/%b want %h/%b", rd, er, ex.rd, ex.er);
                else passed++;
            end
        end
        total++;
        if (blocked != 5) $display("FAIL bp_blocked got %0d want 5", blocked);
        else passed++;
        total++;
        if (sent != 12 || expq.size() != 0)
            $display("FAIL bp_count sent %0d left %0d want 12/0", sent, expq.size());
        else passed++;
    endtask

    task automatic test_random;
        logic acc, rdy, rv, got, er, rr, p_stall, p_er, v, we, sg;
        logic [1:0] sz;
        logic [31:0] rd, p_rd, a;
        exp_t ex;
        int lat;
        p_stall = 1'b0;
        p_rd = '0;
        p_er = 1'b0;
        for (int k = 0; k < 640; k++) begin
            v  = (k < 600) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0) || (k >= 600);
            we = $urandom_range(0, 1) == 1;
            sg = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) a = a + 32'h400 * 32'($urandom_range(1, 4));
            drive(v, we, sz, sg, a, $urandom, rr, acc, rdy, rv, got, rd, er, ex, lat);
            if (p_stall) begin
                total++;
                if (rv !== 1'b1 || rd !== p_rd || er !== p_er)
                    $display("FAIL rnd_hold[%0d] got %b/%h/%b want 1/%h/%b",
                             k, rv, rd, er, p_rd, p_er);
                else passed++;
            end
            p_stall = rv && !rr;
            p_rd = rd;
            p_er = er;
            if (got) begin
                total++;
                if (rd !== ex.rd || er !== ex.er)
                    $display("FAIL rnd_resp[%0d] got %h/%b want %h/%b",
                             k, rd, er, ex.rd, ex.er);
                else passed++;
            end
        end
        total++;
        if (expq.size() != 0) $display("FAIL rnd_drain left got %0d want 0", expq.size());
        else passed++;
    endtask

    task automatic test_reset_inflight;
        logic acc, rdy, rv, got, er;
        logic [31:0] rd;
        exp_t ex;
        int lat, stale, seen;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h030, 32'hA5A55A5A, 1'b1,
              acc, rdy, rv, got, rd, er, ex, lat);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h010, '0, 1'b1,
              acc, rdy, rv, got, rd, er, ex, lat);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h014, '0, 1'b1,
              acc, rdy, rv, got, rd, er, ex, lat);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0)
            $display("FAIL ifr_clear got %b/%h/%b want 0/0/0", resp_valid, resp_rdata, resp_err);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL ifr_hold got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1, acc, rdy, rv, got, rd, er, ex, lat);
            if (rv) stale++;
        end
        total++;
        if (stale != 0) $display("FAIL ifr_stale got %0d want 0", stale);
        else passed++;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            drive(k == 0, 1'b0, 2'd2, 1'b0, 32'h030, '0, 1'b1,
                  acc, rdy, rv, got, rd, er, ex, lat);
            if (got) begin
                seen++;
                total++;
                if (rd !== 32'hA5A55A5A || er !== 1'b0)
                    $display("FAIL ifr_kept got %h/%b want a5a55a5a/0", rd, er);
                else passed++;
            end
        end
        total++;
        if (seen != 1) $display("FAIL ifr_count got %0d want 1", seen);
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32; data word width, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256; number of words, power of two.
REQ-003 SHALL have parameter LATENCY, default 1, legal 1..4; request-accept to response cycles.
REQ-004 SHALL have port clk, input, 1; single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1; request present.
REQ-007 SHALL have port req_ready, output, 1; request accepted when req_valid && req_ready at posedge.
REQ-008 SHALL have port req_we, input, 1; 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2; 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 SHALL have port req_signed, input, 1; sign-extend sub-word loads.
REQ-011 SHALL have port req_addr, input, 32; byte address.
REQ-012 SHALL have port req_wdata, input, DATA_W; store data, right-aligned.
REQ-013 SHALL have port resp_valid, output, 1; response present.
REQ-014 SHALL have port resp_ready, input, 1; response consumed when resp_valid && resp_ready.
REQ-015 SHALL have port resp_rdata, output, DATA_W; load result, extended; 0 for stores and errors.
REQ-016 SHALL have port resp_err, output, 1; misaligned, out-of-range or reserved-size request.

Function
REQ-017 SHALL compute word index = req_addr / (DATA_W/8), byte lane = req_addr mod (DATA_W/8).
REQ-018 SHALL flag error when size is reserved, half not 2-aligned, word not DATA_W/8-aligned, or word index >= DEPTH.
REQ-019 SHALL commit an accepted error-free store at the accept edge, writing only the addressed byte lanes (byte enables from size and lane).
REQ-020 SHALL never modify memory for an errored request.
REQ-021 SHALL sample memory for a load at the accept edge, so a load accepted the cycle after a store to the same word returns the stored bytes.
REQ-022 SHALL extract the addressed lanes, right-align, and zero- or sign-extend per req_signed; word loads ignore req_signed.
REQ-023 SHALL produce exactly one response per accepted request, in acceptance order, LATENCY cycles after accept absent stalls.
REQ-024 SHALL implement a LATENCY-stage valid/data pipeline that advances when the last stage is empty or resp_ready is high.
REQ-025 SHALL drive req_ready = pipeline advance condition; req_ready is combinational from resp_ready and last-stage valid only.
REQ-026 SHALL hold resp_valid, resp_rdata, resp_err stable while resp_valid && !resp_ready.
REQ-027 SHALL sustain one request per cycle when resp_ready stays high.

Reset
REQ-028 SHALL on rst_n low clear all pipeline valid bits; resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1 after reset.
REQ-029 SHALL discard in-flight requests on mid-operation reset; stores already committed remain in memory.
REQ-030 SHALL not clear the memory array on reset; contents are undefined until written.

Structure
REQ-031 SHALL place size encodings (BYTE, HALF, WORD, RSVD) and the legal LATENCY range in shared package dmem_pkg.
REQ-032 SHALL isolate lane extraction and sign/zero extension in sub-module dmem_align.

Verification
REQ-033 SHALL cover: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_rdata 0xDEADBEEF, err 0, LATENCY cycles after accept.
REQ-034 SHALL cover: store byte 0x80 @0x13 over 0xDEADBEEF, load signed byte @0x13 -> 0xFFFFFF80, load word @0x10 -> 0x80ADBEEF.
REQ-035 SHALL cover: load half @0x11 -> err 1, rdata 0; store word @0x400 with DEPTH 256 -> err 1, memory unchanged.
REQ-036 SHALL cover: LATENCY 3, resp_ready low 5 cycles during back-to-back loads -> req_ready low once pipeline full, responses held, in order, none lost.
REQ-037 SHALL cover: store @0x20 then load @0x20 on the next cycle -> new data returned.
REQ-038 SHALL cover: rst_n low with two requests in flight -> resp_valid 0 next cycle, no stale response after release.
